// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and constants for the UART receive path
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } ack_state_e;

   localparam int UART_FRAME_BITS = 10;

   localparam int IRQ_LVL = 0;
   localparam int IRQ_TO  = 1;
   localparam int IRQ_OVR = 2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy counter
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [LW-1:0]    level_o,
   output logic             wr_acc_o,
   output logic             rd_acc_o
);

   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push, pop;

   assign empty_o   = (level_q == '0);
   assign full_o    = (level_q == FULL_LVL);
   assign level_o   = level_q;
   assign rd_data_o = mem_q[rptr_q];

   // A full FIFO still accepts a write when the same cycle frees a slot.
   assign pop      = rd_en_i && !empty_o;
   assign push     = wr_en_i && (!full_o || pop);
   assign wr_acc_o = push;
   assign rd_acc_o = pop;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - drains receiver bytes into a FIFO; overrun, timeout and irq tracking
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter  int DEPTH        = 16,
   parameter  int TIMEOUT_CLKS = 34720,
   localparam int LW           = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_read,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          empty,
   output logic          full,
   output logic [LW-1:0] level,
   input  logic [LW-1:0] thresh,
   input  logic [2:0]    irq_en,
   input  logic          ovr_clr,
   output logic          overrun,
   output logic          timeout,
   output logic          irq
);

   localparam int            TW     = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CLKS);

   ack_state_e    state_q, state_d;
   logic          rx_read_q, rx_read_d;
   logic          overrun_q, overrun_d;
   logic          irq_q, irq_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          push_req;
   logic          wr_acc, rd_acc;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i     (clk),
      .reset_i   (reset),
      .wr_en_i   (push_req),
      .wr_data_i (rx_data),
      .rd_en_i   (rd_en),
      .rd_data_o (rd_data),
      .empty_o   (empty),
      .full_o    (full),
      .level_o   (level),
      .wr_acc_o  (wr_acc),
      .rd_acc_o  (rd_acc)
   );

   // The ACK cycle covers the receiver still holding rx_valid for the byte just taken.
   always_comb begin
      state_d   = state_q;
      rx_read_d = 1'b0;
      push_req  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               push_req  = 1'b1;
               rx_read_d = 1'b1;
               state_d   = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      overrun_d = overrun_q;
      if (push_req && !wr_acc) overrun_d = 1'b1;
      else if (ovr_clr)        overrun_d = 1'b0;
   end

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (wr_acc || rd_acc || empty) to_cnt_d = '0;
      else if (to_cnt_q != TO_MAX)   to_cnt_d = to_cnt_q + TW'(1);
   end

   assign timeout = (to_cnt_q == TO_MAX) && !empty;

   always_comb begin
      irq_d = (irq_en[IRQ_LVL] && (thresh != '0) && (level >= thresh))
            || (irq_en[IRQ_TO]  && timeout)
            || (irq_en[IRQ_OVR] && overrun_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rx_read_q <= 1'b0;
         overrun_q <= 1'b0;
         irq_q     <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         rx_read_q <= rx_read_d;
         overrun_q <= overrun_d;
         irq_q     <= irq_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   assign rx_read = rx_read_q;
   assign overrun = overrun_q;
   assign irq     = irq_q;

endmodule
